// File: rtl/fixed_divider.sv
// fixed_divider: iterative signed fixed-point divider with reserved +Inf/-Inf/NaN codes.
// Optional status flags output is enabled by defining FIXED_DIVIDER_FLAGS_EN.
module fixed_divider #(
  parameter int WIDTH          = 64,
  parameter int FRAC           = 48,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             launch,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
`ifdef FIXED_DIVIDER_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int N    = WIDTH - 1 + FRAC;
  localparam int ITER = (N + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int QW   = ITER * BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [WIDTH-1:0] POS_INF  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_INF  = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] NAN_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-2:0] ONE_M    = {{(WIDTH-2){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    LAST_CNT = CW'(ITER - 1);
  localparam logic [CW-1:0]    ONE_C    = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r;
  logic [QW-1:0]    dq_r;
  logic [WIDTH-2:0] rem_r;
  logic [WIDTH-2:0] div_r;
  logic             sign_r;
  logic             busy_r, done_r;
  logic [WIDTH-1:0] res_r;

  logic             a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic             special_s, spec_nan_s;
  logic [WIDTH-1:0] spec_res_s;
  logic [WIDTH-2:0] mag_a_s, mag_b_s;
  logic [QW-1:0]    dq_load_s;
  logic [WIDTH-1:0] r_v;
  logic [QW-1:0]    x_v;
  logic [WIDTH-2:0] rem_step_s;
  logic [QW-1:0]    dq_step_s;
  logic             q_sat_s, last_s, load_s;
  logic [WIDTH-1:0] q_pos_s, fin_res_s;
  logic             busy_s, done_s;
  logic [WIDTH-1:0] res_s;

`ifdef FIXED_DIVIDER_FLAGS_EN
  logic             spec_dbz_s;
  logic [3:0]       flags_r, flags_s;
`endif

  // Operand classification and special-value result selection
  always_comb begin
    a_nan_s    = (a == NAN_CODE);
    b_nan_s    = (b == NAN_CODE);
    a_inf_s    = (a == POS_INF) || (a == NEG_INF);
    b_inf_s    = (b == POS_INF) || (b == NEG_INF);
    a_zero_s   = (a == ZERO_W);
    b_zero_s   = (b == ZERO_W);
    special_s  = 1'b1;
    spec_nan_s = 1'b0;
    spec_res_s = ZERO_W;
    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s) || (a_zero_s && b_zero_s)) begin
      spec_nan_s = 1'b1;
      spec_res_s = NAN_CODE;
    end else if (b_zero_s) begin
      spec_res_s = a[WIDTH-1] ? NEG_INF : POS_INF;
    end else if (a_inf_s) begin
      spec_res_s = (a[WIDTH-1] ^ b[WIDTH-1]) ? NEG_INF : POS_INF;
    end else if (b_inf_s || a_zero_s) begin
      spec_res_s = ZERO_W;
    end else begin
      special_s = 1'b0;
    end
  end

`ifdef FIXED_DIVIDER_FLAGS_EN
  // Divide-by-zero flag for the special path
  always_comb begin
    spec_dbz_s = b_zero_s && !a_nan_s;
  end
`endif

  // Magnitudes fit in WIDTH-1 bits since the most negative code is NaN
  always_comb begin
    mag_a_s   = a[WIDTH-1] ? (~a[WIDTH-2:0] + ONE_M) : a[WIDTH-2:0];
    mag_b_s   = b[WIDTH-1] ? (~b[WIDTH-2:0] + ONE_M) : b[WIDTH-2:0];
    dq_load_s = {QW{1'b0}};
    dq_load_s[FRAC +: (WIDTH-1)] = mag_a_s;
  end

  // Restoring division: dividend bits leave the top of dq, quotient bits enter the bottom
  always_comb begin
    r_v = {1'b0, rem_r};
    x_v = dq_r;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      r_v = {r_v[WIDTH-2:0], x_v[QW-1]};
      x_v = {x_v[QW-2:0], 1'b0};
      if (r_v >= {1'b0, div_r}) begin
        r_v    = r_v - {1'b0, div_r};
        x_v[0] = 1'b1;
      end else begin
        r_v = r_v;
      end
    end
    rem_step_s = r_v[WIDTH-2:0];
    dq_step_s  = x_v;
  end

  // Final quotient: saturate at or above the +Inf code, otherwise apply sign
  always_comb begin
    q_sat_s = (|dq_step_s[QW-1:WIDTH-1]) || (&dq_step_s[WIDTH-2:0]);
    q_pos_s = {1'b0, dq_step_s[WIDTH-2:0]};
    if (q_sat_s) begin
      fin_res_s = sign_r ? NEG_INF : POS_INF;
    end else if (sign_r) begin
      fin_res_s = ~q_pos_s + ONE_W;
    end else begin
      fin_res_s = q_pos_s;
    end
    last_s = (state_r == S_RUN) && (cnt_r == LAST_CNT);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (launch && !special_s) begin
          state_s = S_RUN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RUN;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs and datapath load
  always_comb begin
    load_s = 1'b0;
    busy_s = 1'b0;
    done_s = 1'b0;
    res_s  = res_r;
`ifdef FIXED_DIVIDER_FLAGS_EN
    flags_s = flags_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (launch && special_s) begin
          done_s = 1'b1;
          res_s  = spec_res_s;
`ifdef FIXED_DIVIDER_FLAGS_EN
          flags_s = {spec_nan_s, spec_dbz_s, 1'b0, 1'b0};
`endif
        end else if (launch) begin
          load_s = 1'b1;
          busy_s = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      S_RUN: begin
        if (last_s) begin
          done_s = 1'b1;
          res_s  = fin_res_s;
`ifdef FIXED_DIVIDER_FLAGS_EN
          flags_s = {1'b0, 1'b0, q_sat_s, (rem_step_s != {(WIDTH-1){1'b0}})};
`endif
        end else begin
          busy_s = 1'b1;
        end
      end
      default: busy_s = 1'b0;
    endcase
  end

  // Datapath registers: operand capture on accept, one step per edge while running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= {CW{1'b0}};
      dq_r   <= {QW{1'b0}};
      rem_r  <= {(WIDTH-1){1'b0}};
      div_r  <= {(WIDTH-1){1'b0}};
      sign_r <= 1'b0;
    end else if (load_s) begin
      cnt_r  <= {CW{1'b0}};
      dq_r   <= dq_load_s;
      rem_r  <= {(WIDTH-1){1'b0}};
      div_r  <= mag_b_s;
      sign_r <= a[WIDTH-1] ^ b[WIDTH-1];
    end else if (state_r == S_RUN) begin
      cnt_r  <= last_s ? {CW{1'b0}} : (cnt_r + ONE_C);
      dq_r   <= dq_step_s;
      rem_r  <= rem_step_s;
    end else begin
      cnt_r  <= cnt_r;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      res_r  <= ZERO_W;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      res_r  <= res_s;
    end
  end

`ifdef FIXED_DIVIDER_FLAGS_EN
  // Status flags, written together with res
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else begin
      flags_r <= flags_s;
    end
  end

  assign flags = flags_r;
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign res  = res_r;

endmodule

// File: tb/tb_fixed_divider.sv
// Directed self-checking bench for fixed_divider (radix 1 and radix 4 instances).
// Flag checks are compiled in when FIXED_DIVIDER_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_fixed_divider;

  localparam int ITER1 = 111;
  localparam int ITER4 = 28;

  localparam logic [63:0] POS_INF  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG_INF  = 64'h8000_0000_0000_0001;
  localparam logic [63:0] NAN_CODE = 64'h8000_0000_0000_0000;

  logic        clk;
  logic        reset;
  logic        launch, launch4;
  logic [63:0] a, b;
  logic        busy, done, busy4, done4;
  logic [63:0] res, res4;
`ifdef FIXED_DIVIDER_FLAGS_EN
  logic [3:0]  flags, flags4;
`endif

  int checks = 0;
  int errors = 0;

  fixed_divider #(.WIDTH(64), .FRAC(48), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .launch(launch), .a(a), .b(b),
    .busy(busy), .done(done), .res(res)
`ifdef FIXED_DIVIDER_FLAGS_EN
    , .flags(flags)
`endif
  );

  fixed_divider #(.WIDTH(64), .FRAC(48), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .launch(launch4), .a(a), .b(b),
    .busy(busy4), .done(done4), .res(res4)
`ifdef FIXED_DIVIDER_FLAGS_EN
    , .flags(flags4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands and a one-cycle launch; returns #1 after the accept edge
  task automatic start_op(input int sel, input logic [63:0] va, input logic [63:0] vb);
    @(negedge clk);
    a = va;
    b = vb;
    if (sel == 0) launch = 1'b1; else launch4 = 1'b1;
    @(posedge clk);
    #1;
    launch  = 1'b0;
    launch4 = 1'b0;
  endtask

  // Bounded wait for done; also notes whether busy stayed high until done
  task automatic wait_done(input int sel, input int max_edges, output int edges,
                           output bit got, output bit busy_ok);
    edges = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && edges < max_edges) begin
      @(posedge clk);
      #1;
      edges++;
      if (((sel == 0) ? done : done4) === 1'b1) begin
        got = 1'b1;
        if (((sel == 0) ? busy : busy4) !== 1'b0) busy_ok = 1'b0;
      end else if (((sel == 0) ? busy : busy4) !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; launch = 1'b0; launch4 = 1'b0; a = 64'h0; b = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (res !== 64'h0) begin errors++; $display("FAIL reset_res: got %h want 0", res); end
    checks++; if ({busy4, done4} !== 2'b00 || res4 !== 64'h0) begin
      errors++; $display("FAIL reset_dut4: got busy=%b done=%b res=%h want 0", busy4, done4, res4);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_divide_basic;
    int e; bit got, bok;
    start_op(0, 64'h0009_0000_0000_0000, 64'h0008_0000_0000_0000);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL basic_accept: got busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(0, ITER1 + 10, e, got, bok);
    checks++; if (!got || e != ITER1) begin errors++; $display("FAIL basic_latency: got %0d edges (done=%b) want %0d", e, got, ITER1); end
    checks++; if (!bok) begin errors++; $display("FAIL basic_busy: busy not high throughout, got 0 want 1"); end
    checks++; if (res !== 64'h0001_2000_0000_0000) begin errors++; $display("FAIL basic_res: got %h want 0001200000000000", res); end
`ifdef FIXED_DIVIDER_FLAGS_EN
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL basic_flags: got %b want 0000", flags); end
`endif
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_after: got done=%b busy=%b want 0 0", done, busy);
    end
    checks++; if (res !== 64'h0001_2000_0000_0000) begin errors++; $display("FAIL basic_hold: got %h want 0001200000000000", res); end
  endtask

  task automatic test_signed;
    int e; bit got, bok;
    start_op(0, 64'h0009_0000_0000_0000, 64'hFFF8_0000_0000_0000);
    wait_done(0, ITER1 + 10, e, got, bok);
    checks++; if (!got || res !== 64'hFFFE_E000_0000_0000) begin
      errors++; $display("FAIL neg_res: got %h (done=%b) want fffee00000000000", res, got);
    end
    start_op(0, 64'hFFFE_8000_0000_0000, 64'h0000_8000_0000_0000);
    wait_done(0, ITER1 + 10, e, got, bok);
    checks++; if (!got || res !== 64'hFFFD_0000_0000_0000) begin
      errors++; $display("FAIL neg_a_res: got %h (done=%b) want fffd000000000000", res, got);
    end
    start_op(0, 64'hFFFF_0000_0000_0000, 64'h0003_0000_0000_0000);
    wait_done(0, ITER1 + 10, e, got, bok);
    checks++; if (!got || res !== 64'hFFFF_AAAA_AAAA_AAAB) begin
      errors++; $display("FAIL third_res: got %h (done=%b) want ffffaaaaaaaaaaab", res, got);
    end
`ifdef FIXED_DIVIDER_FLAGS_EN
    checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL third_flags: got %b want 0001", flags); end
`endif
  endtask

  task automatic test_radix4;
    int e; bit got, bok;
    start_op(1, 64'h0009_0000_0000_0000, 64'hFFF8_0000_0000_0000);
    wait_done(1, ITER4 + 10, e, got, bok);
    checks++; if (!got || e != ITER4) begin errors++; $display("FAIL r4_latency: got %0d edges (done=%b) want %0d", e, got, ITER4); end
    checks++; if (!bok) begin errors++; $display("FAIL r4_busy: busy not high throughout, got 0 want 1"); end
    checks++; if (res4 !== 64'hFFFE_E000_0000_0000) begin errors++; $display("FAIL r4_res: got %h want fffee00000000000", res4); end
`ifdef FIXED_DIVIDER_FLAGS_EN
    checks++; if (flags4 !== 4'b0000) begin errors++; $display("FAIL r4_flags: got %b want 0000", flags4); end
`endif
  endtask

  task automatic test_underflow;
    int e; bit got, bok;
    start_op(0, 64'h0000_0000_0000_0001, 64'h0002_0000_0000_0000);
    wait_done(0, ITER1 + 10, e, got, bok);
    checks++; if (!got || res !== 64'h0) begin errors++; $display("FAIL underflow_res: got %h (done=%b) want 0", res, got); end
`ifdef FIXED_DIVIDER_FLAGS_EN
    checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL underflow_flags: got %b want 0001", flags); end
`endif
  endtask

  task automatic test_specials;
    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic [63:0] vr [4];
    logic [3:0]  vf [4];
    va[0] = NEG_INF;                vb[0] = 64'h2; vr[0] = NEG_INF;  vf[0] = 4'b0000;
    va[1] = POS_INF;                vb[1] = NEG_INF; vr[1] = NAN_CODE; vf[1] = 4'b1000;
    va[2] = 64'h0005_0000_0000_0000; vb[2] = 64'h0; vr[2] = POS_INF;  vf[2] = 4'b0100;
    va[3] = 64'h0;                  vb[3] = 64'h0; vr[3] = NAN_CODE; vf[3] = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      start_op(0, va[i], vb[i]);
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL special%0d_hs: got done=%b busy=%b want 1 0", i, done, busy);
      end
      checks++; if (res !== vr[i]) begin errors++; $display("FAIL special%0d_res: got %h want %h", i, res, vr[i]); end
`ifdef FIXED_DIVIDER_FLAGS_EN
      checks++; if (flags !== vf[i]) begin errors++; $display("FAIL special%0d_flags: got %b want %b", i, flags, vf[i]); end
`else
      vf[i] = 4'b0000;
`endif
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL special%0d_after: got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_overflow;
    int e; bit got, bok;
    start_op(0, 64'h7FFF_0000_0000_0000, 64'h0000_0000_0000_0001);
    wait_done(0, ITER1 + 10, e, got, bok);
    checks++; if (!got || res !== POS_INF) begin errors++; $display("FAIL overflow_res: got %h (done=%b) want %h", res, got, POS_INF); end
`ifdef FIXED_DIVIDER_FLAGS_EN
    checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL overflow_flags: got %b want 0010", flags); end
`endif
  endtask

  task automatic test_reset_abort;
    int dones;
    start_op(0, 64'h0009_0000_0000_0000, 64'h0008_0000_0000_0000);
    repeat (50) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || res !== 64'h0) begin
      errors++; $display("FAIL abort_state: got busy=%b res=%h want 0 0", busy, res);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (ITER1 + 10) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    checks++; if (dones != 0 || res !== 64'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_nodone: got dones=%0d res=%h busy=%b want 0 0 0", dones, res, busy);
    end
  endtask

  task automatic test_launch_busy;
    int e, dones; bit got, bok;
    start_op(0, 64'h0009_0000_0000_0000, 64'h0008_0000_0000_0000);
    repeat (10) @(posedge clk);
    #1;
    a = 64'h0001_0000_0000_0000;
    b = 64'h0003_0000_0000_0000;
    launch = 1'b1;
    @(posedge clk);
    #1;
    launch = 1'b0;
    wait_done(0, ITER1, e, got, bok);
    checks++; if (!got || e != ITER1 - 11) begin errors++; $display("FAIL midbusy_latency: got %0d edges (done=%b) want %0d", e, got, ITER1 - 11); end
    checks++; if (res !== 64'h0001_2000_0000_0000) begin errors++; $display("FAIL midbusy_res: got %h want 0001200000000000", res); end
    dones = 0;
    repeat (ITER1 + 10) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++; if (dones != 0 || res !== 64'h0001_2000_0000_0000) begin
      errors++; $display("FAIL midbusy_queued: got activity=%0d res=%h want 0 0001200000000000", dones, res);
    end
  endtask

  task automatic test_back_to_back;
    int e; bit got, bok;
    start_op(0, 64'hFFFE_8000_0000_0000, 64'h0000_8000_0000_0000);
    wait_done(0, ITER1 + 10, e, got, bok);
    checks++; if (!got || res !== 64'hFFFD_0000_0000_0000) begin
      errors++; $display("FAIL b2b_first: got %h (done=%b) want fffd000000000000", res, got);
    end
    a = 64'h0001_0000_0000_0000;
    b = 64'h0003_0000_0000_0000;
    launch = 1'b1;
    @(posedge clk);
    #1;
    launch = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: got done=%b busy=%b want 0 1", done, busy);
    end
    wait_done(0, ITER1 + 10, e, got, bok);
    checks++; if (!got || e != ITER1 || res !== 64'h0000_5555_5555_5555) begin
      errors++; $display("FAIL b2b_second: got %h after %0d edges want 0000555555555555 after %0d", res, e, ITER1);
    end
  endtask

  initial begin
    test_reset();
    test_divide_basic();
    test_signed();
    test_radix4();
    test_underflow();
    test_specials();
    test_overflow();
    test_reset_abort();
    test_launch_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
